// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// A start pulse loads the operand; BIN_W shift cycles later the result is
// presented on bcd together with a one-cycle done pulse and an overflow flag
// that reports when the true value needed more than DIGITS decimal digits.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [0:0] {
        IDLE_S  = 1'b0,
        SHIFT_S = 1'b1
    } state_t;

    state_t             state_r;
    logic [BIN_W-1:0]   shift_r;
    logic [BCD_W-1:0]   work_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_r;

    logic [BCD_W-1:0]   adj_s;
    logic [4:0]         dig_s;
    logic               top_carry_s;
    logic [BCD_W-1:0]   work_nxt_s;
    logic [BIN_W-1:0]   shift_nxt_s;
    logic               ovf_hit_s;

    // Adds 3 to a digit of 5 or more; bit 4 is the carry out of the nibble.
    function automatic logic [4:0] add3_fn(input logic [3:0] d);
        logic [4:0] r;
        if (d >= 4'd5) begin
            r = {1'b0, d} + 5'd3;
        end else begin
            r = {1'b0, d};
        end
        return r;
    endfunction

    // Digit adjust for the current working value, tracking the top digit's carry.
    always_comb begin
        adj_s       = '0;
        dig_s       = '0;
        top_carry_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            dig_s              = add3_fn(work_r[4*i +: 4]);
            adj_s[4*i +: 4]    = dig_s[3:0];
            if (i == DIGITS - 1) begin
                top_carry_s = dig_s[4];
            end else begin
                top_carry_s = top_carry_s;
            end
        end
    end

    // One shift step: the top adjusted bit falls off (truncation) and flags overflow.
    always_comb begin
        work_nxt_s  = {adj_s[BCD_W-2:0], shift_r[BIN_W-1]};
        shift_nxt_s = shift_r << 1;
        ovf_hit_s   = top_carry_s | adj_s[BCD_W-1];
    end

    // Control FSM with working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE_S;
            shift_r  <= '0;
            work_r   <= '0;
            cnt_r    <= '0;
            ovf_r    <= 1'b0;
            bcd      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state_r)
                IDLE_S: begin
                    done <= 1'b0;
                    if (start) begin
                        shift_r <= bin;
                        work_r  <= '0;
                        cnt_r   <= CNT_W'(BIN_W);
                        ovf_r   <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= SHIFT_S;
                    end else begin
                        state_r <= IDLE_S;
                    end
                end
                SHIFT_S: begin
                    work_r  <= work_nxt_s;
                    shift_r <= shift_nxt_s;
                    ovf_r   <= ovf_r | ovf_hit_s;
                    cnt_r   <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        bcd      <= work_nxt_s;
                        overflow <= ovf_r | ovf_hit_s;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state_r  <= IDLE_S;
                    end else begin
                        done     <= 1'b0;
                        state_r  <= SHIFT_S;
                    end
                end
                default: begin
                    state_r <= IDLE_S;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three parameterisations share one clock and reset.
// A vector table drives single conversions; hand sequences cover busy,
// back-to-back and reset-abort behaviour. Results go through a scoreboard.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start_a = 1'b0, busy_a, done_a, ovf_a;
    logic [7:0]  bin_a = '0;
    logic [11:0] bcd_a;
    logic        start_b = 1'b0, busy_b, done_b, ovf_b;
    logic [7:0]  bin_b = '0;
    logic [7:0]  bcd_b;
    logic        start_c = 1'b0, busy_c, done_c, ovf_c;
    logic [15:0] bin_c = '0;
    logic [19:0] bcd_c;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dcnt_a = 0;
    int last_done_a = 0;
    int prev_done_a = 0;

    typedef struct {
        logic [19:0] bcd;
        logic        ovf;
    } exp_t;

    typedef struct {
        int          dut;
        int          w;
        logic [15:0] bin;
        logic [19:0] bcd;
        logic        ovf;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    vec_t vecs [11];

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
        .bcd(bcd_a), .busy(busy_a), .done(done_a), .overflow(ovf_a)
    );
    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
        .bcd(bcd_b), .busy(busy_b), .done(done_b), .overflow(ovf_b)
    );
    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .bin(bin_c),
        .bcd(bcd_c), .busy(busy_c), .done(done_c), .overflow(ovf_c)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure back-to-back spacing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic get_busy(input int d);
        case (d)
            0: return busy_a;
            1: return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic get_done(input int d);
        case (d)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic [19:0] get_bcd(input int d);
        case (d)
            0: return {8'd0, bcd_a};
            1: return {12'd0, bcd_b};
            default: return bcd_c;
        endcase
    endfunction

    task automatic drive(input int d, input logic s, input logic [15:0] b);
        case (d)
            0: begin start_a = s; bin_a = b[7:0]; end
            1: begin start_b = s; bin_b = b[7:0]; end
            default: begin start_c = s; bin_c = b; end
        endcase
    endtask

    task automatic push(input int d, input logic [19:0] e, input logic o);
        exp_t x;
        x.bcd = e;
        x.ovf = o;
        case (d)
            0: q_a.push_back(x);
            1: q_b.push_back(x);
            default: q_c.push_back(x);
        endcase
    endtask

    // Scoreboard: every done pulse pops one expected result per instance.
    always @(negedge clk) begin
        exp_t e;
        if (done_a) begin
            dcnt_a      <= dcnt_a + 1;
            prev_done_a <= last_done_a;
            last_done_a <= cyc;
            if (q_a.size() == 0) begin
                chk("unexpected_done_a", 32'd1, 32'd0);
            end else begin
                e = q_a.pop_front();
                chk("bcd_a", {20'd0, bcd_a}, {12'd0, e.bcd});
                chk("ovf_a", {31'd0, ovf_a}, {31'd0, e.ovf});
            end
        end
        if (done_b) begin
            if (q_b.size() == 0) begin
                chk("unexpected_done_b", 32'd1, 32'd0);
            end else begin
                e = q_b.pop_front();
                chk("bcd_b", {24'd0, bcd_b}, {12'd0, e.bcd});
                chk("ovf_b", {31'd0, ovf_b}, {31'd0, e.ovf});
            end
        end
        if (done_c) begin
            if (q_c.size() == 0) begin
                chk("unexpected_done_c", 32'd1, 32'd0);
            end else begin
                e = q_c.pop_front();
                chk("bcd_c", {12'd0, bcd_c}, {12'd0, e.bcd});
                chk("ovf_c", {31'd0, ovf_c}, {31'd0, e.ovf});
            end
        end
    end

    // Single conversion with busy-length, result-hold and done-pulse checks.
    task automatic conv(input int d, input int w, input logic [15:0] b,
                        input logic [19:0] e, input logic o);
        logic [19:0] prev;
        int n;
        bit stable;
        push(d, e, o);
        @(negedge clk);
        prev = get_bcd(d);
        drive(d, 1'b1, b);
        @(negedge clk);
        drive(d, 1'b0, ~b);
        n = 0;
        stable = 1'b1;
        while (get_busy(d) && n < 40) begin
            n++;
            if (get_bcd(d) !== prev) stable = 1'b0;
            @(negedge clk);
        end
        chk("busy_len", n, w);
        chk("bcd_hold", {31'd0, stable}, 32'd1);
        chk("done_pulse", {31'd0, get_done(d)}, 32'd1);
        @(negedge clk);
        chk("done_clear", {31'd0, get_done(d)}, 32'd0);
    endtask

    initial begin
        int n;
        int base;
        vecs[0]  = '{0, 8,  16'h0020, 20'h00032, 1'b0};
        vecs[1]  = '{0, 8,  16'h0010, 20'h00016, 1'b0};
        vecs[2]  = '{0, 8,  16'd255,  20'h00255, 1'b0};
        vecs[3]  = '{0, 8,  16'd0,    20'h00000, 1'b0};
        vecs[4]  = '{0, 8,  16'd99,   20'h00099, 1'b0};
        vecs[5]  = '{0, 8,  16'd100,  20'h00100, 1'b0};
        vecs[6]  = '{1, 8,  16'd99,   20'h00099, 1'b0};
        vecs[7]  = '{1, 8,  16'd100,  20'h00000, 1'b1};
        vecs[8]  = '{1, 8,  16'd255,  20'h00055, 1'b1};
        vecs[9]  = '{2, 16, 16'd65535, 20'h65535, 1'b0};
        vecs[10] = '{2, 16, 16'd10000, 20'h10000, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_bcd_a", {20'd0, bcd_a}, 32'd0);
        chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
        chk("rst_done_a", {31'd0, done_a}, 32'd0);
        chk("rst_ovf_a", {31'd0, ovf_a}, 32'd0);
        chk("rst_busy_bc", {30'd0, busy_b, busy_c}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            conv(vecs[i].dut, vecs[i].w, vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
        end

        // start pulsed mid-conversion is ignored and not queued
        push(0, 20'h00200, 1'b0);
        @(negedge clk); drive(0, 1'b1, 16'd200);
        @(negedge clk); drive(0, 1'b0, 16'd200);
        @(negedge clk);
        @(negedge clk); drive(0, 1'b1, 16'd7);
        @(negedge clk); drive(0, 1'b0, 16'd7);
        n = 0;
        while (busy_a && n < 40) begin n++; @(negedge clk); end
        @(negedge clk); #1;
        base = dcnt_a;
        repeat (12) @(negedge clk);
        #1;
        chk("no_second_done", dcnt_a, base);

        // start held high: second conversion accepted in the done cycle
        push(0, 20'h00200, 1'b0);
        push(0, 20'h00007, 1'b0);
        base = dcnt_a;
        @(negedge clk); drive(0, 1'b1, 16'd200);
        @(negedge clk); drive(0, 1'b1, 16'd7);
        n = 0;
        while (dcnt_a < base + 2 && n < 60) begin @(negedge clk); #1; n++; end
        drive(0, 1'b0, 16'd7);
        chk("b2b_dones", dcnt_a - base, 2);
        chk("b2b_gap", last_done_a - prev_done_a, 9);
        @(negedge clk);

        // reset four edges into a conversion aborts it
        @(negedge clk); drive(0, 1'b1, 16'd123);
        @(negedge clk); drive(0, 1'b0, 16'd123);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        chk("abort_done", {31'd0, done_a}, 32'd0);
        chk("abort_bcd", {20'd0, bcd_a}, 32'd0);
        chk("abort_ovf", {31'd0, ovf_a}, 32'd0);
        rst = 1'b0;
        #1;
        base = dcnt_a;
        repeat (12) @(negedge clk);
        #1;
        chk("abort_no_done", dcnt_a, base);
        conv(0, 8, 16'd45, 20'h00045, 1'b0);

        repeat (3) @(negedge clk);
        chk("queues_empty", q_a.size() + q_b.size() + q_c.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
